// File: rtl/ascon_fc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ascon_fc_sequencer
// Brief    : Word-bus loader and run controller for the fault-countermeasure
//            Ascon wrapper. Loads key/nonce/AD/PT, pulses encryption then
//            decryption start, waits on the ready levels with a timeout, and
//            presents the captured results through a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module ascon_fc_sequencer #(
  parameter int K       = 128,
  parameter int L       = 40,
  parameter int Y       = 40,
  parameter int W       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,                    // asynchronous, active-low
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic           in_ready,
  output logic [K-1:0]   key,
  output logic [127:0]   nonce,
  output logic [L-1:0]   associated_data,
  output logic [Y-1:0]   plain_text,
  output logic           encryption_start,
  output logic           decryption_start,
  input  logic [Y-1:0]   cipher_text,
  input  logic [127:0]   tag,
  input  logic           encryption_ready,
  input  logic           decryption_ready,
  input  logic           message_authentication,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [Y-1:0]   res_cipher_text,
  output logic [127:0]   res_tag,
  output logic           res_auth,
  output logic           res_timeout,
  output logic           busy
);

  localparam int NK = (K + W - 1) / W;
  localparam int NN = (128 + W - 1) / W;
  localparam int NA = (L + W - 1) / W;
  localparam int NP = (Y + W - 1) / W;
  localparam int NT = NK + NN + NA + NP;
  localparam int CW = $clog2(NT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // Word-index boundaries between the fields in load order
  localparam logic [CW-1:0] KEY_END   = CW'(NK);
  localparam logic [CW-1:0] NONCE_END = CW'(NK + NN);
  localparam logic [CW-1:0] AD_END    = CW'(NK + NN + NA);
  localparam logic [CW-1:0] LAST_WORD = CW'(NT - 1);
  localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_LOAD      = 3'd0,
    S_ENC_START = 3'd1,
    S_ENC_WAIT  = 3'd2,
    S_DEC_START = 3'd3,
    S_DEC_WAIT  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [K-1:0]    key_q, key_d;
  logic [127:0]    nonce_q, nonce_d;
  logic [L-1:0]    ad_q, ad_d;
  logic [Y-1:0]    pt_q, pt_d;
  logic [Y-1:0]    res_ct_q, res_ct_d;
  logic [127:0]    res_tag_q, res_tag_d;
  logic            res_auth_q, res_auth_d;
  logic            res_to_q, res_to_d;

  // Shifted candidates: the new word enters at the LSBs, oldest bits fall off the top
  logic [K+W-1:0]   key_sh;
  logic [128+W-1:0] nonce_sh;
  logic [L+W-1:0]   ad_sh;
  logic [Y+W-1:0]   pt_sh;

  assign key_sh   = {key_q, in_data};
  assign nonce_sh = {nonce_q, in_data};
  assign ad_sh    = {ad_q, in_data};
  assign pt_sh    = {pt_q, in_data};

  // Timer==0 masks a ready level left over from the previous run
  logic timer_nz;
  logic timer_max;
  assign timer_nz  = (timer_q != '0);
  assign timer_max = (timer_q == TMAX);

  // State, counters, field and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LOAD;
      cnt_q      <= '0;
      timer_q    <= '0;
      key_q      <= '0;
      nonce_q    <= '0;
      ad_q       <= '0;
      pt_q       <= '0;
      res_ct_q   <= '0;
      res_tag_q  <= '0;
      res_auth_q <= 1'b0;
      res_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      key_q      <= key_d;
      nonce_q    <= nonce_d;
      ad_q       <= ad_d;
      pt_q       <= pt_d;
      res_ct_q   <= res_ct_d;
      res_tag_q  <= res_tag_d;
      res_auth_q <= res_auth_d;
      res_to_q   <= res_to_d;
    end
  end

  // Next-state, load steering, timer and result capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    key_d      = key_q;
    nonce_d    = nonce_q;
    ad_d       = ad_q;
    pt_d       = pt_q;
    res_ct_d   = res_ct_q;
    res_tag_d  = res_tag_q;
    res_auth_d = res_auth_q;
    res_to_d   = res_to_q;

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          if (cnt_q < KEY_END)        key_d   = key_sh[K-1:0];
          else if (cnt_q < NONCE_END) nonce_d = nonce_sh[127:0];
          else if (cnt_q < AD_END)    ad_d    = ad_sh[L-1:0];
          else                        pt_d    = pt_sh[Y-1:0];
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = S_ENC_START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ENC_START: begin
        timer_d = '0;
        state_d = S_ENC_WAIT;
      end
      S_ENC_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (encryption_ready && timer_nz) begin
          state_d = S_DEC_START;
        end else if (timer_max) begin
          res_ct_d   = '0;
          res_tag_d  = '0;
          res_auth_d = 1'b0;
          res_to_d   = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DEC_START: begin
        timer_d = '0;
        state_d = S_DEC_WAIT;
      end
      S_DEC_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (decryption_ready && timer_nz) begin
          res_ct_d   = cipher_text;
          res_tag_d  = tag;
          res_auth_d = message_authentication;
          res_to_d   = 1'b0;
          state_d    = S_DONE;
        end else if (timer_max) begin
          res_ct_d   = '0;
          res_tag_d  = '0;
          res_auth_d = 1'b0;
          res_to_d   = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign in_ready         = (state_q == S_LOAD);
  assign busy             = (state_q != S_LOAD);
  assign encryption_start = (state_q == S_ENC_START);
  assign decryption_start = (state_q == S_DEC_START);
  assign res_valid        = (state_q == S_DONE);

  assign key             = key_q;
  assign nonce           = nonce_q;
  assign associated_data = ad_q;
  assign plain_text      = pt_q;
  assign res_cipher_text = res_ct_q;
  assign res_tag         = res_tag_q;
  assign res_auth        = res_auth_q;
  assign res_timeout     = res_to_q;

endmodule
`default_nettype wire
